// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives a req/ack instruction-memory port and
// feeds {instr, instr_pc, instr_valid} into the IF/ID register.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        misaligned_fault
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    START = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pend_pc;
  logic              pend_bad;
  logic [XLEN-1:0]   skid_data;
  logic [XLEN-1:0]   skid_pc;

  logic              fire;
  logic              slot_free;
  logic              bad_tgt;
  logic [XLEN-1:0]   pc_next;

  // pc is frozen while draining, so it doubles as the outstanding address.
  assign imem_req  = (state == REQ) || (state == DRAIN);
  assign imem_addr = pc;

  assign fire      = imem_req && imem_ack;
  assign slot_free = !instr_valid || !stall;
  assign bad_tgt   = (redirect_pc[1:0] != 2'b00);
  assign pc_next   = pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= START;
      pc               <= RESET_PC;
      pend_pc          <= RESET_PC;
      pend_bad         <= 1'b0;
      skid_data        <= NOP_INSTR;
      skid_pc          <= '0;
      instr            <= NOP_INSTR;
      instr_pc         <= '0;
      instr_valid      <= 1'b0;
      misaligned_fault <= 1'b0;
    end else begin
      // Decode took the current word; refill below or fall back to a bubble.
      if (instr_valid && !stall) begin
        instr       <= NOP_INSTR;
        instr_valid <= 1'b0;
      end

      if (redirect) begin
        instr            <= NOP_INSTR;
        instr_valid      <= 1'b0;
        misaligned_fault <= bad_tgt;
        if ((state == REQ || state == DRAIN) && !fire) begin
          // Request still in flight: remember the target until it retires.
          pend_pc  <= redirect_pc;
          pend_bad <= bad_tgt;
          state    <= DRAIN;
        end else begin
          if (!bad_tgt) begin
            pc <= redirect_pc;
          end
          state <= bad_tgt ? FAULT : REQ;
        end
      end else begin
        case (state)
          START: state <= REQ;
          REQ: begin
            if (imem_ack) begin
              pc <= pc_next;
              if (slot_free) begin
                instr       <= imem_rdata;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
              end else begin
                skid_data <= imem_rdata;
                skid_pc   <= pc;
                state     <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!stall) begin
              instr       <= skid_data;
              instr_pc    <= skid_pc;
              instr_valid <= 1'b1;
              state       <= REQ;
            end
          end
          DRAIN: begin
            if (imem_ack) begin
              if (pend_bad) begin
                state <= FAULT;
              end else begin
                pc    <= pend_pc;
                state <= REQ;
              end
            end
          end
          FAULT: state <= FAULT;
          default: state <= START;
        endcase
      end
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side producer for the IF/ID pipeline register.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake that tolerates variable latency.
- Hands {instr, instr_pc, instr_valid} to the IF/ID register. The IF/ID register captures them on every clk edge.
- Handles decode back-pressure (stall), branch/jump redirect, and misaligned-target faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr when invalid (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; held until imem_ack.
- imem_addr  output  32  fetch byte address; stable while imem_req=1.
- imem_ack  input  1  response valid; imem_rdata valid in the same cycle. May be the same cycle as req (zero-wait memory).
- imem_rdata  input  32  fetched instruction word.
- stall  input  1  decode cannot accept; holds the current instr.
- redirect  input  1  one-cycle pulse: change PC to redirect_pc.
- redirect_pc  input  32  redirect target.
- instr  output  32  instruction to IF/ID.
- instr_pc  output  32  PC of instr.
- instr_valid  output  1  instr is live.
- misaligned_fault  output  1  latched: last redirect target had redirect_pc[1:0]!=0.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC; state=START; instr=NOP_INSTR; instr_pc=0; instr_valid=0; misaligned_fault=0; skid empty.
  - imem_req is 0 while in reset and while in START.
- Handshake:
  - imem_req=1 in states REQ and DRAIN. Combinational from state.
  - imem_addr=pc in REQ; the latched old address in DRAIN.
  - Transaction completes in any cycle with imem_req && imem_ack.
  - imem_req and imem_addr must not change before completion.
- Slot rules:
  - Output slot is free when !instr_valid || !stall.
  - Slot is consumed when instr_valid && !stall.
  - A consumed slot with no new data loads NOP_INSTR and instr_valid=0.
- States:
  - START: go to REQ next cycle. The first imem_req is high in the 2nd cycle after rst falls.
  - REQ:
    - On ack, slot free: instr<=imem_rdata; instr_pc<=pc; instr_valid<=1; pc<=pc+4; stay in REQ.
    - On ack, slot not free: data goes to the 1-entry skid register (data+pc); pc<=pc+4; go to HOLD.
    - No ack: stay in REQ.
  - HOLD: imem_req=0. When !stall, skid moves to the slot (valid=1), skid is emptied, and the state goes to REQ.
  - DRAIN: an outstanding request is being discarded. Keep req/addr stable. On ack, drop the data, set pc<=pending target, and go to REQ.
  - FAULT: imem_req=0 and instr_valid=0. Leave only via a redirect with an aligned target (go to REQ) or via rst.
- Latency and throughput:
  - ack at edge T means instr_valid=1 after edge T.
  - With zero-wait memory and no stall, throughput is 1 instr/cycle.
- Redirect (priority over ack, stall, and the skid):
  - Next cycle: instr_valid=0, instr=NOP_INSTR, skid emptied.
  - From REQ with no ack this cycle: latch the target, go to DRAIN.
  - From REQ with ack this cycle: discard the data, pc<=redirect_pc, stay in REQ.
  - From START, HOLD, or FAULT: pc<=redirect_pc, go to REQ.
  - In DRAIN: overwrite the pending target; the newest redirect wins.
  - If redirect_pc[1:0]!=0: misaligned_fault<=1, go to FAULT (DRAIN first completes its ack). No fetch is issued to the misaligned address.
  - An aligned redirect clears misaligned_fault.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. pc[1:0] is always 0.
- Reset mid-transaction: an outstanding request is abandoned. A late imem_ack while in START is ignored.

Test Plan:
- Zero-wait memory (ack=req, rdata=addr^32'hA5A5_0000), RESET_PC=0, no stall -> instr_pc sequence 0,4,8,C on consecutive cycles; instr_valid continuous from the 3rd cycle after reset release.
- Memory with 3-cycle ack latency -> imem_addr held at 0x4 for all wait cycles; one valid instr per 4 cycles; instr_valid=0 between them.
- stall=1 for 3 cycles while ack arrives -> instr held at 0x4's word; 0x8's word goes to the skid; imem_req=0 in HOLD; after stall falls, instr_pc goes 0x8 then 0xC; no instruction is lost or duplicated.
- redirect to 0x100 while a 0x10 request waits on ack -> imem_addr stays 0x10 until ack, that data is dropped, next request addr=0x100, first valid instr_pc=0x100.
- redirect_pc=0x102 -> misaligned_fault=1, imem_req=0, instr_valid=0; then redirect_pc=0x200 -> fault clears and fetch resumes at 0x200.
- RESET_PC=32'hFFFF_FFF8 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; rst pulsed mid-wait -> all outputs return to their reset values at the next edge.
